ras_ckpt: RTL and testbench
===========================

Name: ras_ckpt

Overview:
Parametrised return address stack (RAS) for the fetch-stage branch predictor. It generalises the fixed-depth RAS to configurable depth and address width. New features over the fixed RAS:
- circular overflow: the oldest entry is overwritten when the stack is full;
- combined pop+push: a single-cycle top replacement for co-routine jumps;
- single-level checkpoint/restore for recovery from speculative calls/returns on branch misprediction.
The BPU pushes on calls and pops on returns. The commit/branch unit drives checkpoint, restore and flush.

Parameters:
DEPTH, 8, number of stack entries; power of two, >= 2
ADDR_W, 64, width of a stored return address
CNT_W, $clog2(DEPTH)+1, derived; width of count_o (localparam, not overridable)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous, active-high reset
flush_i  in  1  empty stack and invalidate checkpoint
push_i  in  1  push push_addr_i (call)
push_addr_i  in  ADDR_W  return address to push
pop_i  in  1  pop top entry (return)
ckpt_i  in  1  capture current state into checkpoint
restore_i  in  1  restore state from checkpoint
top_valid_o  out  1  stack non-empty
top_addr_o  out  ADDR_W  current top entry; 0 when empty
count_o  out  CNT_W  number of valid entries, 0..DEPTH
ckpt_valid_o  out  1  a checkpoint is held
overflow_o  out  1  comb.: this cycle's push overwrites the oldest entry
underflow_o  out  1  comb.: this cycle's pop finds the stack empty

Behaviour:
- State:
  - tos_q: log2(DEPTH) bits, top index.
  - cnt_q: CNT_W bits.
  - mem[DEPTH]: ADDR_W bits each, not reset.
  - Checkpoint: ck_tos_q, ck_cnt_q, ck_top_q (ADDR_W), ck_valid_q.
- Reset (rst_i=1 at clock edge):
  - tos_q=0, cnt_q=0, ck_valid_q=0, ck_* = 0.
  - Resulting outputs: top_valid_o=0, top_addr_o=0, count_o=0, ckpt_valid_o=0.
  - Reset has priority over all inputs, including mid-operation.
- Outputs are combinational from registered state:
  - top_valid_o = (cnt_q != 0).
  - top_addr_o = top_valid_o ? mem[tos_q] : 0.
  - An update written at edge N is visible after edge N (zero-latency read of the new top in cycle N+1).
- Priority per cycle: rst_i > flush_i > restore_i > push/pop. ckpt_i is independent of push/pop but suppressed by rst_i, flush_i and restore_i.
- flush_i: cnt_q=0, tos_q=0, ck_valid_q=0. push/pop/ckpt are ignored that cycle.
- restore_i with ck_valid_q=1:
  - tos_q=ck_tos_q, cnt_q=ck_cnt_q, mem[ck_tos_q]=ck_top_q.
  - push/pop/ckpt are ignored. ck_valid_q stays 1, so repeated restores are allowed.
- restore_i with ck_valid_q=0: behaves exactly as flush_i.
- push only:
  - tos_q=tos_q+1 (mod DEPTH), mem[tos_q+1]=push_addr_i, cnt_q=min(cnt_q+1, DEPTH).
  - overflow_o=1 iff cnt_q==DEPTH.
- pop only:
  - If cnt_q>0: tos_q=tos_q-1 (mod DEPTH), cnt_q=cnt_q-1.
  - If cnt_q==0: no state change, underflow_o=1.
- push and pop together:
  - If cnt_q>0: mem[tos_q]=push_addr_i; tos_q and cnt_q are unchanged.
  - If cnt_q==0: behaves as push only; underflow_o=0, overflow_o=0.
- ckpt_i:
  - Captures pre-update state: ck_tos_q=tos_q, ck_cnt_q=cnt_q, ck_top_q=mem[tos_q], ck_valid_q=1.
  - A same-cycle push/pop still updates the live stack.
- Overflow/underflow outputs are forced to 0 in any cycle where flush_i, restore_i or rst_i is active.
- Wrap-around: tos_q arithmetic is modulo DEPTH. After DEPTH+k pushes, the k oldest entries are lost and cnt_q saturates at DEPTH.
- Restore correctness is limited to the top entry. Entries below the top that were overwritten after the checkpoint are not recovered. This is accepted by design.

Test Plan:
- DEPTH=4. Reset, then push 0x100, 0x200, 0x300 -> count_o=3, top_addr_o=0x300; pop twice -> top_addr_o=0x100, count_o=1.
- Push 0x10..0x50 (5 pushes) -> 5th push cycle overflow_o=1, count_o=4. Then 4 pops return 0x50, 0x40, 0x30, 0x20. 5th pop -> underflow_o=1, count_o stays 0, top_addr_o=0.
- Stack [0xA, 0xB] (top 0xB). Assert push+pop with push_addr_i=0xC -> count_o=2, top_addr_o=0xC. Pop -> top 0xA.
- Stack [0xA, 0xB]. Assert ckpt_i with pop in the same cycle -> top 0xA, ckpt_valid_o=1. Push 0xD, then restore_i -> count_o=2, top_addr_o=0xB. Restore again -> same result.
- restore_i with ckpt_valid_o=0 on a stack of 3 entries -> count_o=0, top_valid_o=0. flush_i together with push_i 0x99 -> count_o=0, ckpt_valid_o=0.
- Reset asserted in the same cycle as push_i + ckpt_i on a full stack -> next cycle count_o=0, ckpt_valid_o=0, overflow_o=0. A push after reset gives count_o=1.

Source files
------------

// File: rtl/ras_ckpt.sv
// Parametrised return address stack with circular overflow, combined
// pop+push top replacement and a single-level checkpoint/restore.
module ras_ckpt #(
  parameter int unsigned  DEPTH  = 8,
  parameter int unsigned  ADDR_W = 64,
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic              pop_i,
  input  logic              ckpt_i,
  input  logic              restore_i,
  output logic              top_valid_o,
  output logic [ADDR_W-1:0] top_addr_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              ckpt_valid_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int unsigned      IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  logic [IDX_W-1:0]  tos_q, tos_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0]  ck_tos_q, ck_tos_d;
  logic [CNT_W-1:0]  ck_cnt_q, ck_cnt_d;
  logic [ADDR_W-1:0] ck_top_q, ck_top_d;
  logic              ck_valid_q, ck_valid_d;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [ADDR_W-1:0] mem_wdata;

  // Read side: top-of-stack view straight from registered state
  always_comb begin
    top_valid_o  = (cnt_q != '0);
    top_addr_o   = top_valid_o ? mem_q[tos_q] : '0;
    count_o      = cnt_q;
    ckpt_valid_o = ck_valid_q;
  end

  // Next-state: rst > flush (or restore without checkpoint) > restore > push/pop
  always_comb begin
    tos_d       = tos_q;
    cnt_d       = cnt_q;
    ck_tos_d    = ck_tos_q;
    ck_cnt_d    = ck_cnt_q;
    ck_top_d    = ck_top_q;
    ck_valid_d  = ck_valid_q;
    mem_we      = 1'b0;
    mem_waddr   = tos_q;
    mem_wdata   = push_addr_i;
    overflow_o  = 1'b0;
    underflow_o = 1'b0;

    if (rst_i) begin
      // state cleared in the flop block; no writes, no flags
    end else if (flush_i || (restore_i && !ck_valid_q)) begin
      tos_d      = '0;
      cnt_d      = '0;
      ck_valid_d = 1'b0;
    end else if (restore_i) begin
      // Only the top entry is recovered; deeper overwritten entries stay lost
      tos_d     = ck_tos_q;
      cnt_d     = ck_cnt_q;
      mem_we    = 1'b1;
      mem_waddr = ck_tos_q;
      mem_wdata = ck_top_q;
    end else begin
      if (ckpt_i) begin
        ck_tos_d   = tos_q;
        ck_cnt_d   = cnt_q;
        ck_top_d   = mem_q[tos_q];
        ck_valid_d = 1'b1;
      end
      if (push_i && pop_i && (cnt_q != '0)) begin
        mem_we    = 1'b1;
        mem_waddr = tos_q;
      end else if (push_i) begin
        // Also covers push+pop on an empty stack
        tos_d     = tos_q + 1'b1;
        mem_we    = 1'b1;
        mem_waddr = tos_q + 1'b1;
        if (cnt_q == FULL) begin
          overflow_o = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (pop_i) begin
        if (cnt_q != '0) begin
          tos_d = tos_q - 1'b1;
          cnt_d = cnt_q - 1'b1;
        end else begin
          underflow_o = 1'b1;
        end
      end
    end
  end

  // Pointer, count and checkpoint registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tos_q      <= '0;
      cnt_q      <= '0;
      ck_tos_q   <= '0;
      ck_cnt_q   <= '0;
      ck_top_q   <= '0;
      ck_valid_q <= 1'b0;
    end else begin
      tos_q      <= tos_d;
      cnt_q      <= cnt_d;
      ck_tos_q   <= ck_tos_d;
      ck_cnt_q   <= ck_cnt_d;
      ck_top_q   <= ck_top_d;
      ck_valid_q <= ck_valid_d;
    end
  end

  // Entry storage, single write port, not reset
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_ras_ckpt.sv
// Scoreboard bench for ras_ckpt (DEPTH=4, ADDR_W=32). Each stimulus cycle
// queues the outputs expected during that cycle: registered state left by
// the previous cycle plus the combinational overflow/underflow flags.
module tb_ras_ckpt;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              push = 1'b0;
  logic [ADDR_W-1:0] push_addr = '0;
  logic              pop = 1'b0;
  logic              ckpt = 1'b0;
  logic              restore = 1'b0;
  logic              top_valid;
  logic [ADDR_W-1:0] top_addr;
  logic [CNT_W-1:0]  count;
  logic              ckpt_valid;
  logic              overflow;
  logic              underflow;

  ras_ckpt #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .push_i      (push),
    .push_addr_i (push_addr),
    .pop_i       (pop),
    .ckpt_i      (ckpt),
    .restore_i   (restore),
    .top_valid_o (top_valid),
    .top_addr_o  (top_addr),
    .count_o     (count),
    .ckpt_valid_o(ckpt_valid),
    .overflow_o  (overflow),
    .underflow_o (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          chk_state;
    int unsigned cnt;
    int unsigned top;
    bit          ckv;
    bit          ov;
    bit          uf;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string nm, input string fld, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare one entry per cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cmp(e.name, "overflow", 32'(overflow), 32'(e.ov));
        cmp(e.name, "underflow", 32'(underflow), 32'(e.uf));
        if (e.chk_state) begin
          cmp(e.name, "count", 32'(count), e.cnt);
          cmp(e.name, "top_valid", 32'(top_valid), 32'(e.cnt != 0));
          cmp(e.name, "top_addr", top_addr, e.top);
          cmp(e.name, "ckpt_valid", 32'(ckpt_valid), 32'(e.ckv));
        end
      end
    end
  end

  // One stimulus cycle: ops for this cycle, state expected from the previous one
  task automatic cyc(input string nm,
                     input bit r, input bit f, input bit rs,
                     input bit ps, input bit pp, input bit ck,
                     input int unsigned a,
                     input bit chk, input int unsigned c, input int unsigned t,
                     input bit kv, input bit ov, input bit uf);
    exp_t e;
    @(posedge clk);
    #2;
    rst = r; flush = f; restore = rs; push = ps; pop = pp; ckpt = ck;
    push_addr = a;
    e.name = nm; e.chk_state = chk; e.cnt = c; e.top = t;
    e.ckv = kv; e.ov = ov; e.uf = uf;
    sb_q.push_back(e);
  endtask

  initial begin
    //   name          r f rs ps pp ck addr   chk cnt top   ckv ov uf
    cyc("reset",       1,0,0, 0,0,0, 0,     0,  0, 0,    0,  0, 0);
    // basic push/pop
    cyc("push100",     0,0,0, 1,0,0, 'h100, 1,  0, 0,    0,  0, 0);
    cyc("push200",     0,0,0, 1,0,0, 'h200, 1,  1, 'h100,0,  0, 0);
    cyc("push300",     0,0,0, 1,0,0, 'h300, 1,  2, 'h200,0,  0, 0);
    cyc("pop1",        0,0,0, 0,1,0, 0,     1,  3, 'h300,0,  0, 0);
    cyc("pop2",        0,0,0, 0,1,0, 0,     1,  2, 'h200,0,  0, 0);
    cyc("after_pops",  0,0,0, 0,0,0, 0,     1,  1, 'h100,0,  0, 0);
    cyc("drain",       0,0,0, 0,1,0, 0,     1,  1, 'h100,0,  0, 0);
    // overflow wrap and underflow
    cyc("push10",      0,0,0, 1,0,0, 'h10,  1,  0, 0,    0,  0, 0);
    cyc("push20",      0,0,0, 1,0,0, 'h20,  1,  1, 'h10, 0,  0, 0);
    cyc("push30",      0,0,0, 1,0,0, 'h30,  1,  2, 'h20, 0,  0, 0);
    cyc("push40",      0,0,0, 1,0,0, 'h40,  1,  3, 'h30, 0,  0, 0);
    cyc("push50_ovf",  0,0,0, 1,0,0, 'h50,  1,  4, 'h40, 0,  1, 0);
    cyc("popA",        0,0,0, 0,1,0, 0,     1,  4, 'h50, 0,  0, 0);
    cyc("popB",        0,0,0, 0,1,0, 0,     1,  3, 'h40, 0,  0, 0);
    cyc("popC",        0,0,0, 0,1,0, 0,     1,  2, 'h30, 0,  0, 0);
    cyc("popD",        0,0,0, 0,1,0, 0,     1,  1, 'h20, 0,  0, 0);
    cyc("pop_udf",     0,0,0, 0,1,0, 0,     1,  0, 0,    0,  0, 1);
    cyc("after_udf",   0,0,0, 0,0,0, 0,     1,  0, 0,    0,  0, 0);
    // combined push+pop
    cyc("pushA",       0,0,0, 1,0,0, 'hA,   1,  0, 0,    0,  0, 0);
    cyc("pushB",       0,0,0, 1,0,0, 'hB,   1,  1, 'hA,  0,  0, 0);
    cyc("pushpopC",    0,0,0, 1,1,0, 'hC,   1,  2, 'hB,  0,  0, 0);
    cyc("pop_afterC",  0,0,0, 0,1,0, 0,     1,  2, 'hC,  0,  0, 0);
    // checkpoint + restore
    cyc("pushB2",      0,0,0, 1,0,0, 'hB,   1,  1, 'hA,  0,  0, 0);
    cyc("ckpt_pop",    0,0,0, 0,1,1, 0,     1,  2, 'hB,  0,  0, 0);
    cyc("pushD",       0,0,0, 1,0,0, 'hD,   1,  1, 'hA,  1,  0, 0);
    cyc("restore1",    0,0,1, 0,0,0, 0,     1,  2, 'hD,  1,  0, 0);
    cyc("restore2",    0,0,1, 0,0,0, 0,     1,  2, 'hB,  1,  0, 0);
    cyc("flush1",      0,1,0, 0,0,0, 0,     1,  2, 'hB,  1,  0, 0);
    // restore without checkpoint, flush with push
    cyc("push1",       0,0,0, 1,0,0, 'h1,   1,  0, 0,    0,  0, 0);
    cyc("push2",       0,0,0, 1,0,0, 'h2,   1,  1, 'h1,  0,  0, 0);
    cyc("push3",       0,0,0, 1,0,0, 'h3,   1,  2, 'h2,  0,  0, 0);
    cyc("restore_nock",0,0,1, 0,0,0, 0,     1,  3, 'h3,  0,  0, 0);
    cyc("push5",       0,0,0, 1,0,0, 'h5,   1,  0, 0,    0,  0, 0);
    cyc("ckpt_only",   0,0,0, 0,0,1, 0,     1,  1, 'h5,  0,  0, 0);
    cyc("flush_push99",0,1,0, 1,0,0, 'h99,  1,  1, 'h5,  1,  0, 0);
    cyc("flush_popemp",0,1,0, 0,1,0, 0,     1,  0, 0,    0,  0, 0);
    // reset mid-operation on a full stack
    cyc("fill1",       0,0,0, 1,0,0, 'h1,   1,  0, 0,    0,  0, 0);
    cyc("fill2",       0,0,0, 1,0,0, 'h2,   1,  1, 'h1,  0,  0, 0);
    cyc("fill3",       0,0,0, 1,0,0, 'h3,   1,  2, 'h2,  0,  0, 0);
    cyc("fill4",       0,0,0, 1,0,0, 'h4,   1,  3, 'h3,  0,  0, 0);
    cyc("rst_push_ck", 1,0,0, 1,0,1, 'h5,   1,  4, 'h4,  0,  0, 0);
    cyc("push77",      0,0,0, 1,0,0, 'h77,  1,  0, 0,    0,  0, 0);
    // push+pop on an empty stack acts as push
    cyc("pop77",       0,0,0, 0,1,0, 0,     1,  1, 'h77, 0,  0, 0);
    cyc("pushpop_emp", 0,0,0, 1,1,0, 'hE,   1,  0, 0,    0,  0, 0);
    cyc("final",       0,0,0, 0,0,0, 0,     1,  1, 'hE,  0,  0, 0);

    // Let the monitor drain the scoreboard, bounded
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
